// File: rtl/udp_tx_scheduler.sv
// udp_tx_scheduler: resolves the peer MAC via ARP, then cuts bytes from the
// sample FIFO (1-cycle read latency) into UDP frames for the stack send port.
// Frames are full length, or shorter after a flush timeout. An idle gap
// follows every frame.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   IDLE     | scheduling disabled, waiting for i_enable
//   ARP_REQ  | one-cycle ARP request pulse, counts the attempt
//   ARP_WAIT | waiting for the ARP reply or for the retry timer to expire
//   READY    | resolved; waiting for a full frame or a flush timeout
//   SEND     | reading len bytes from the FIFO and streaming them out
//   GAP      | mandatory idle time after the last byte of a frame
module udp_tx_scheduler #(
  parameter int P_FRAME_LEN = 512,
  parameter int P_GAP_CYC   = 64,
  parameter int P_FLUSH_CYC = 100000,
  parameter int P_ARP_RETRY = 125000,
  parameter int P_ARP_MAX   = 8
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_enable,
  input  logic [15:0] i_fifo_count,
  input  logic [7:0]  i_fifo_data,
  output logic        o_fifo_rd,
  input  logic        i_arp_valid,
  output logic        o_arp_req,
  output logic        o_arp_fail,
  input  logic        i_send_ready,
  output logic [15:0] o_send_len,
  output logic [7:0]  o_send_data,
  output logic        o_send_last,
  output logic        o_send_valid,
  output logic [31:0] o_frame_cnt,
  output logic        o_busy
);

  // One down-counter serves the retry, flush and gap timers; they never overlap.
  localparam int T_MAX1 = (P_ARP_RETRY > P_FLUSH_CYC) ? P_ARP_RETRY : P_FLUSH_CYC;
  localparam int T_MAX  = (T_MAX1 > P_GAP_CYC) ? T_MAX1 : P_GAP_CYC;
  localparam int TW     = $clog2(T_MAX + 1);
  localparam int RW     = $clog2(P_ARP_MAX + 1);

  // ARP_WAIT lasts P_ARP_RETRY-1 cycles so request pulses are P_ARP_RETRY apart.
  localparam logic [TW-1:0] T_ARP   = TW'(P_ARP_RETRY - 2);
  localparam logic [TW-1:0] T_FLUSH = TW'(P_FLUSH_CYC);
  localparam logic [TW-1:0] T_GAP   = TW'(P_GAP_CYC - 1);
  localparam logic [RW-1:0] ARP_MAX    = RW'(P_ARP_MAX);
  localparam logic [RW-1:0] ARP_MAX_M1 = RW'(P_ARP_MAX - 1);
  localparam logic [15:0]   FRAME_LEN  = 16'(P_FRAME_LEN);

  typedef enum logic [2:0] {IDLE, ARP_REQ, ARP_WAIT, READY, SEND, GAP} state_t;

  state_t        state, state_nxt;
  logic [TW-1:0] tmr;
  logic [RW-1:0] retry_cnt;
  logic          resolved;
  logic [15:0]   rd_left;
  logic [15:0]   len;
  logic          full, partial, start;

  assign full    = (i_fifo_count >= FRAME_LEN);
  assign partial = (i_fifo_count != 16'd0) && !full;
  // Full wins over flush when both hold, because len saturates at FRAME_LEN.
  assign start   = i_enable && i_send_ready && (full || (partial && tmr == '0));
  assign len     = full ? FRAME_LEN : i_fifo_count;

  assign o_arp_req   = (state == ARP_REQ);
  assign o_busy      = !((state == IDLE) || (state == READY));
  assign o_fifo_rd   = (state == SEND) && (rd_left != 16'd0);
  // FIFO data arrives one cycle after the strobe, exactly when valid is high.
  assign o_send_data = o_send_valid ? i_fifo_data : 8'h00;

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (i_enable) state_nxt = resolved ? READY : ARP_REQ;
      ARP_REQ:  state_nxt = ARP_WAIT;
      ARP_WAIT: begin
        if (resolved || i_arp_valid) state_nxt = READY;
        else if (tmr == '0)          state_nxt = ARP_REQ;
      end
      READY: begin
        if (!i_enable)  state_nxt = IDLE;
        else if (start) state_nxt = SEND;
      end
      SEND:     if (o_send_last) state_nxt = GAP;
      GAP:      if (tmr == '0) state_nxt = READY;
      default:  state_nxt = IDLE;
    endcase
  end

  // Shared timer: reload on state entry, count down inside the owning state.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      tmr <= '0;
    end else if (state_nxt != state) begin
      case (state_nxt)
        ARP_WAIT: tmr <= T_ARP;
        READY:    tmr <= T_FLUSH;
        GAP:      tmr <= T_GAP;
        default:  tmr <= '0;
      endcase
    end else begin
      case (state)
        ARP_WAIT, GAP: if (tmr != '0) tmr <= tmr - TW'(1);
        READY: begin
          if (!partial)        tmr <= T_FLUSH;
          else if (tmr != '0)  tmr <= tmr - TW'(1);
        end
        default: tmr <= tmr;
      endcase
    end
  end

  // ARP bookkeeping: resolved flag, attempt count and sticky failure flag.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      resolved   <= 1'b0;
      retry_cnt  <= '0;
      o_arp_fail <= 1'b0;
    end else begin
      if (i_arp_valid) resolved <= 1'b1;
      if (state == ARP_REQ) begin
        if (retry_cnt != ARP_MAX) retry_cnt <= retry_cnt + RW'(1);
        if (retry_cnt >= ARP_MAX_M1) o_arp_fail <= 1'b1;
      end
      if (state == ARP_WAIT && (resolved || i_arp_valid)) begin
        retry_cnt  <= '0;
        o_arp_fail <= 1'b0;
      end
    end
  end

  // Frame datapath: read countdown, valid/last pipeline, length and frame count.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rd_left      <= 16'd0;
      o_send_len   <= 16'd0;
      o_send_valid <= 1'b0;
      o_send_last  <= 1'b0;
      o_frame_cnt  <= 32'd0;
    end else begin
      o_send_valid <= o_fifo_rd;
      o_send_last  <= o_fifo_rd && (rd_left == 16'd1);
      if (state == READY && state_nxt == SEND) begin
        rd_left    <= len;
        o_send_len <= len;
      end else if (o_fifo_rd) begin
        rd_left <= rd_left - 16'd1;
      end
      if (state == SEND && o_send_last) o_frame_cnt <= o_frame_cnt + 32'd1;
    end
  end

endmodule
